// File: rtl/edge_detect_multi.sv
// Multi-channel edge detector: per-channel glitch filter, polarity select,
// pulse stretching with re-trigger holdoff, sticky missed flags and saturating event counters.
module edge_detect_multi #(
  parameter int NCH     = 8,
  parameter int FILT    = 2,
  parameter int STRETCH = 4,
  parameter int HOLDOFF = 16,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NCH-1:0]     sig,
  input  logic [1:0]         mode,
  input  logic               en,
  input  logic               clr_cnt,
  output logic [NCH-1:0]     pulse,
  output logic               any_pulse,
  output logic [NCH-1:0]     missed,
  output logic [NCH*CNT_W-1:0] evt_cnt
);

  localparam int FC_W = (FILT > 1) ? $clog2(FILT + 1) : 1;
  localparam int HC_W = $clog2(HOLDOFF + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PULSE = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  localparam logic [FC_W-1:0]  FILT_LAST    = FC_W'(FILT - 1);
  localparam logic [HC_W-1:0]  STRETCH_LAST = HC_W'(STRETCH - 1);
  localparam logic [HC_W-1:0]  HOLD_LAST    = HC_W'(HOLDOFF - 1);
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;
  // When the holdoff ends no later than the cycle after the pulse, skip HOLD entirely.
  localparam bit SKIP_HOLD = (HOLDOFF <= STRETCH + 1);

  logic                           primed_q, primed_d;
  logic [NCH-1:0]                 lvl_q, lvl_d;
  logic [NCH-1:0][FC_W-1:0]       fcnt_q, fcnt_d;
  logic [NCH-1:0][1:0]            state_q, state_d;
  logic [NCH-1:0][HC_W-1:0]       hc_q, hc_d;
  logic [NCH-1:0]                 pulse_q, pulse_d;
  logic [NCH-1:0]                 missed_q, missed_d;
  logic [NCH-1:0][CNT_W-1:0]      cnt_q, cnt_d;

  logic [NCH-1:0] flip;
  logic [NCH-1:0] qual;
  logic [NCH-1:0] accept;
  logic [NCH-1:0] drop;

  always_comb begin
    primed_d = 1'b1;
    lvl_d    = lvl_q;
    fcnt_d   = fcnt_q;
    state_d  = state_q;
    hc_d     = hc_q;
    pulse_d  = pulse_q;
    missed_d = missed_q;
    cnt_d    = cnt_q;
    flip     = '0;
    qual     = '0;
    accept   = '0;
    drop     = '0;

    for (int i = 0; i < NCH; i++) begin
      // Filter: the first primed edge only captures the level.
      if (!primed_q) begin
        lvl_d[i]  = sig[i];
        fcnt_d[i] = '0;
      end else if (sig[i] != lvl_q[i]) begin
        if (fcnt_q[i] == FILT_LAST) begin
          flip[i]   = 1'b1;
          lvl_d[i]  = sig[i];
          fcnt_d[i] = '0;
        end else begin
          fcnt_d[i] = fcnt_q[i] + 1'b1;
        end
      end else begin
        fcnt_d[i] = '0;
      end

      qual[i] = flip[i] & (lvl_q[i] ? mode[1] : mode[0]);

      case (state_q[i])
        S_IDLE: begin
          accept[i] = qual[i] & en;
          drop[i]   = qual[i] & ~en;
        end
        S_PULSE: begin
          drop[i] = qual[i];
          hc_d[i] = hc_q[i] + 1'b1;
          if (hc_q[i] == STRETCH_LAST) begin
            pulse_d[i] = 1'b0;
            state_d[i] = SKIP_HOLD ? S_IDLE : S_HOLD;
          end
        end
        S_HOLD: begin
          drop[i] = qual[i];
          hc_d[i] = hc_q[i] + 1'b1;
          if (hc_d[i] == HOLD_LAST) begin
            state_d[i] = S_IDLE;
          end
        end
        default: begin
          state_d[i] = S_IDLE;
          pulse_d[i] = 1'b0;
        end
      endcase

      if (accept[i]) begin
        pulse_d[i] = 1'b1;
        hc_d[i]    = '0;
        state_d[i] = S_PULSE;
      end

      // Clear applies first so a same-edge event or drop still registers.
      cnt_d[i] = clr_cnt ? '0 : cnt_q[i];
      if (accept[i] && (cnt_d[i] != CNT_MAX)) begin
        cnt_d[i] = cnt_d[i] + 1'b1;
      end
      missed_d[i] = (clr_cnt ? 1'b0 : missed_q[i]) | drop[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      primed_q <= 1'b0;
      lvl_q    <= '0;
      fcnt_q   <= '0;
      state_q  <= '0;
      hc_q     <= '0;
      pulse_q  <= '0;
      missed_q <= '0;
      cnt_q    <= '0;
    end else begin
      primed_q <= primed_d;
      lvl_q    <= lvl_d;
      fcnt_q   <= fcnt_d;
      state_q  <= state_d;
      hc_q     <= hc_d;
      pulse_q  <= pulse_d;
      missed_q <= missed_d;
      cnt_q    <= cnt_d;
    end
  end

  assign pulse     = pulse_q;
  assign any_pulse = |pulse_q;
  assign missed    = missed_q;
  assign evt_cnt   = cnt_q;

endmodule
